// File: rtl/sar_search8_pkg.sv
// Shared types and constants for the successive-approximation search engine.
package sar_search8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } sar_state_t;

  // Offset-binary conversion mask: SIGNED << (WIDTH-1).
  // XOR with this flips the MSB so a signed range searches like an unsigned one.
  function automatic int unsigned off_mask(input int signed_mode, input int width);
    return (signed_mode != 0) ? (32'd1 << (width - 1)) : 32'd0;
  endfunction

endpackage

// File: rtl/sar_search8.sv
// MSB-first successive-approximation search driving an external comparator.
// The accumulator is kept offset-binary so one search loop serves both the
// signed and unsigned ranges; only the MSB is flipped on the way out.
module sar_search8
  import sar_search8_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SIGNED  = 1,
  parameter int CMP_LAT = 0
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic             GT,
  output logic [WIDTH-1:0] TRIAL,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
  localparam logic [WIDTH-1:0] C_OFF   = WIDTH'(off_mask(SIGNED, WIDTH));
  localparam logic [BW-1:0]    C_MSB   = BW'(WIDTH - 1);
  localparam logic [CW-1:0]    C_WLOAD = CW'((CMP_LAT > 0) ? (CMP_LAT - 1) : 0);

  sar_state_t       r_state, w_next;
  logic [WIDTH-1:0] r_acc;
  logic [BW-1:0]    r_bit;
  logic [CW-1:0]    r_wcnt;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_cand;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_sample;
  logic             w_last;
  logic             w_busy;

  // Candidate = settled bits plus the bit under test; GT=1 means too high, drop the bit.
  assign w_cand    = r_acc | (WIDTH'(1) << r_bit);
  assign w_acc_nxt = GT ? r_acc : w_cand;
  assign w_last    = (r_bit == '0);
  assign w_busy    = (r_state == ST_PROBE) || (r_state == ST_WAIT);
  // GT is consumed only at the end of each bit step.
  assign w_sample  = ((r_state == ST_PROBE) && (CMP_LAT == 0)) ||
                     ((r_state == ST_WAIT) && (r_wcnt == '0));

  assign TRIAL  = w_busy ? (w_cand ^ C_OFF) : '0;
  assign BUSY   = w_busy;
  assign DONE   = (r_state == ST_FIN);
  assign RESULT = r_result;

  // State register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state: one PROBE (+ CMP_LAT WAIT cycles) per bit, then a single FIN cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (START) w_next = ST_PROBE;
      ST_PROBE: if (CMP_LAT > 0) w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_WAIT;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (w_sample) w_next = w_last ? ST_FIN : ST_PROBE;
  end

  // Datapath: accumulator, bit pointer, comparator wait counter, result latch.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_acc    <= '0;
      r_bit    <= '0;
      r_wcnt   <= '0;
      r_result <= '0;
    end else begin
      if ((r_state == ST_IDLE) && START) begin
        r_acc <= '0;
        r_bit <= C_MSB;
      end
      if ((r_state == ST_PROBE) && (CMP_LAT > 0)) r_wcnt <= C_WLOAD;
      else if ((r_state == ST_WAIT) && (r_wcnt != '0)) r_wcnt <= r_wcnt - 1'b1;
      if (w_sample) begin
        r_acc <= w_acc_nxt;
        if (w_last) r_result <= w_acc_nxt ^ C_OFF;
        else        r_bit    <= r_bit - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sar_search8.sv
// Bench: three search engines (signed/comb, unsigned/comb, signed/2-cycle compare)
// each closed through a behavioural comparator against a bench-held target.
module tb_sar_search8;
  localparam int NI = 3;
  localparam int SG[NI] = '{1, 0, 1};
  localparam int LT[NI] = '{0, 0, 2};

  typedef struct {
    logic [7:0] res;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] start = '0;
  logic [NI-1:0] gt, busy, done;
  logic [7:0] trial [NI];
  logic [7:0] result[NI];
  logic [7:0] tgt   [NI];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t sb[NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sar_search8 #(.WIDTH(8), .SIGNED(SG[g]), .CMP_LAT(LT[g])) u_dut (
      .CLK(clk), .RESETN(rst_n), .START(start[g]), .GT(gt[g]),
      .TRIAL(trial[g]), .BUSY(busy[g]), .DONE(done[g]), .RESULT(result[g])
    );
    // Comparator model: 1 iff TRIAL > target in the instance's number system.
    assign gt[g] = (SG[g] != 0) ? ($signed(trial[g]) > $signed(tgt[g])) : (trial[g] > tgt[g]);

    exp_t e;
    // Scoreboard: every DONE must match the oldest outstanding search.
    always @(negedge clk) begin
      if (done[g]) begin
        if (sb[g].size() == 0) chk($sformatf("spurious_done%0d", g), 32'(done[g]), 32'd0);
        else begin
          e = sb[g].pop_front();
          chk($sformatf("result%0d", g), 32'(result[g]), 32'(e.res));
          chk($sformatf("latency%0d", g), 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Pulse START for one cycle with a target and record the expected outcome.
  task automatic kick(input int g, input logic [7:0] t);
    @(posedge clk); #1;
    tgt[g] = t;
    start[g] = 1'b1;
    sb[g].push_back('{res: t, cyc: cyc + 8 * (LT[g] + 1) + 1});
    @(posedge clk); #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int n = 0;
    while (sb[g].size() != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    if (sb[g].size() != 0) chk($sformatf("timeout%0d", g), 32'(sb[g].size()), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [7:0] seq1[8] = '{8'h00, 8'h40, 8'h20, 8'h30, 8'h28, 8'h24, 8'h26, 8'h25};
  logic [7:0] seq4[6] = '{8'h00, 8'h00, 8'h00, 8'hC0, 8'hC0, 8'hC0};

  initial begin
    for (int g = 0; g < NI; g++) tgt[g] = 8'h00;
    // Reset state
    #12;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst_trial%0d", g), 32'(trial[g]), 0);
      chk($sformatf("rst_busy%0d", g), 32'(busy[g]), 0);
      chk($sformatf("rst_done%0d", g), 32'(done[g]), 0);
      chk($sformatf("rst_result%0d", g), 32'(result[g]), 0);
    end
    @(posedge clk); #1; rst_n = 1'b1;

    // Signed search for 37, trial sequence per bit
    kick(0, 8'd37);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t1_trial%0d", i), 32'(trial[0]), 32'(seq1[i]));
      chk("t1_busy", 32'(busy[0]), 1);
    end
    wait_done(0);
    chk("t1_hold", 32'(result[0]), 32'h25);
    chk("t1_idle_trial", 32'(trial[0]), 0);
    chk("t1_idle_busy", 32'(busy[0]), 0);

    // Signed boundaries
    kick(0, 8'h80); wait_done(0);
    kick(0, 8'h7F); wait_done(0);
    kick(0, 8'hFF); wait_done(0);

    // Unsigned: 200 plus both range ends
    kick(1, 8'd200);
    @(negedge clk);
    chk("t3_first_trial", 32'(trial[1]), 32'h80);
    wait_done(1);
    kick(1, 8'h00); wait_done(1);
    kick(1, 8'hFF); wait_done(1);

    // Comparator latency 2: trial held three cycles per bit
    kick(2, 8'hFB);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t4_trial%0d", i), 32'(trial[2]), 32'(seq4[i]));
    end
    wait_done(2);

    // START re-pulsed mid-search is ignored
    kick(0, 8'd37);
    repeat (2) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    wait_done(0);

    // Reset mid-search: async clear, no DONE, then normal convergence
    kick(0, 8'd100);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    sb[0].delete();
    chk("t6_trial", 32'(trial[0]), 0);
    chk("t6_busy", 32'(busy[0]), 0);
    chk("t6_done", 32'(done[0]), 0);
    chk("t6_result", 32'(result[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    kick(0, 8'hEC); wait_done(0);

    repeat (3) @(posedge clk);
    for (int g = 0; g < NI; g++) chk($sformatf("pending%0d", g), 32'(sb[g].size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute safety bound on simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
